// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator and registered pixel output stage.
// A clock divider produces the pixel tick. The x/y counters walk the whole raster,
// including blanking. Colour and sync are registered one tick behind the counters,
// so rgb/hs/vs stay mutually aligned. frame_start marks the wrap back to (0,0).
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] vgaData,
    output logic [9:0]  xPos,
    output logic [9:0]  yPos,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Reject geometries the 10-bit counters or the divider cannot represent.
    generate
        if (H_TOTAL > 1024) begin : g_bad_h_total
            $error("vga_sync_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_bad_v_total
            $error("vga_sync_gen: V_TOTAL exceeds 1024");
        end
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("vga_sync_gen: CLK_DIV must be at least 2");
        end
    endgenerate

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic [11:0]      r_rgb;
    logic             r_hs;
    logic             r_vs;
    logic             r_frame_start;

    logic w_tick;
    logic w_x_last;
    logic w_y_last;
    logic w_active;
    logic w_hs_on;
    logic w_vs_on;

    // Decodes of the current counter values; all comparisons are unsigned.
    assign w_tick   = (r_div == DIV_LAST);
    assign w_x_last = (r_x == H_LAST);
    assign w_y_last = (r_y == V_LAST);
    assign w_active = (r_x < H_VIS) && (r_y < V_VIS);
    assign w_hs_on  = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
    assign w_vs_on  = (r_y >= VS_FIRST) && (r_y <= VS_LAST);

    // Pixel-tick divider: free-running count 0..CLK_DIV-1.
    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Raster counters: x walks the line, y advances as x wraps, both wrap at their totals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_tick) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    // Output stage: colour and syncs registered from the current coordinates, one tick behind them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= 12'h000;
            r_hs  <= ~SYNC_POL;
            r_vs  <= ~SYNC_POL;
        end else if (w_tick) begin
            r_rgb <= w_active ? vgaData : 12'h000;
            r_hs  <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            r_vs  <= w_vs_on ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Frame marker: single-clk pulse raised by the tick that wraps the raster to (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && w_x_last && w_y_last;
        end
    end

    assign xPos        = r_x;
    assign yPos        = r_y;
    assign r           = r_rgb[11:8];
    assign g           = r_rgb[7:4];
    assign b           = r_rgb[3:0];
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign frame_start = r_frame_start;

endmodule
